// File: rtl/sha256_padder_if.sv
// rtl/sha256_padder_if.sv - byte input stream and 512-bit block port of the SHA-256 padder
interface sha256_padder_if;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic [511:0] blk_data;
  logic         blk_ready;

  modport master (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_first, blk_last, blk_data
  );

  modport slave (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_first, blk_last, blk_data
  );
endinterface

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder and 512-bit block sequencer
module sha256_padder #(
  parameter int CNT_W = 61
) (
  input  logic           clk,
  input  logic           rst,
  sha256_padder_if.master bus
);

  localparam logic [1:0] ACC  = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic [1:0]       state;
  logic [511:0]     blk_buf;
  logic [511:0]     acc_buf;
  logic [5:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             first_pend;
  logic             tail_pend;
  logic             tail_mark;
  logic             in_ready_q;
  logic             blk_valid_q;
  logic             blk_first_q;
  logic             blk_last_q;
  logic [8:0]       wr_pos;
  logic [8:0]       pad_pos;
  logic             accept;
  logic             blk_xfer;

  function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
    logic [CNT_W+2:0] b;
    b = {c, 3'b000};
    return 64'(b);
  endfunction

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.blk_data  = blk_buf;

  // in_ready is only ever high in ACC, so it doubles as the state qualifier
  assign accept   = bus.in_valid && in_ready_q;
  assign blk_xfer = blk_valid_q && bus.blk_ready;
  assign cnt_inc  = cnt + 1'b1;

  // Byte j lives at [(63-j)*8 +: 8]; ~idx is 63-idx
  assign wr_pos  = {~idx, 3'b000};
  assign pad_pos = {~idx - 6'd1, 3'b000};

  always_comb begin
    acc_buf = blk_buf;
    acc_buf[wr_pos +: 8] = bus.in_data;
    if (bus.in_last && idx != 6'd63) acc_buf[pad_pos +: 8] = 8'h80;
    if (bus.in_last && idx <= 6'd54) acc_buf[63:0] = bit_len(cnt_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ACC;
      blk_buf     <= '0;
      idx         <= '0;
      cnt         <= '0;
      first_pend  <= 1'b1;
      tail_pend   <= 1'b0;
      tail_mark   <= 1'b0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            blk_buf <= acc_buf;
            idx     <= idx + 6'd1;
            cnt     <= cnt_inc;
            if (bus.in_last || idx == 6'd63) begin
              state       <= EMIT;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
              blk_first_q <= first_pend;
              blk_last_q  <= bus.in_last && idx <= 6'd54;
              if (bus.in_last && idx >= 6'd55) begin
                tail_pend <= 1'b1;
                tail_mark <= (idx == 6'd63);
              end
            end
          end
        end
        EMIT: begin
          if (blk_xfer) begin
            blk_valid_q <= 1'b0;
            blk_buf     <= '0;
            idx         <= '0;
            first_pend  <= 1'b0;
            if (tail_pend) begin
              state     <= TAIL;
              tail_pend <= 1'b0;
            end else begin
              state      <= ACC;
              in_ready_q <= 1'b1;
              if (blk_last_q) begin
                cnt        <= '0;
                first_pend <= 1'b1;
              end
            end
          end
        end
        TAIL: begin
          // cnt already holds the full message length here
          blk_buf     <= {(tail_mark ? 8'h80 : 8'h00), 440'd0, bit_len(cnt)};
          tail_mark   <= 1'b0;
          blk_first_q <= first_pend;
          blk_last_q  <= 1'b1;
          blk_valid_q <= 1'b1;
          state       <= EMIT;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - scoreboard bench for sha256_padder with a FIPS 180-4 padding model
module tb_sha256_padder;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_padder_if bus();
  sha256_padder #(.CNT_W(61)) dut (.clk(clk), .rst(rst), .bus(bus));

  blk_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   rdy_mode = 1;
  bit   rand_idle = 1'b0;

  task automatic check(input string name, input logic [519:0] act, input logic [519:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: append 0x80, zero to 56 mod 64, 64-bit big-endian bit length, cut into 64-byte blocks
  function automatic void model(input bq_t m);
    bq_t p;
    logic [63:0] bl;
    blk_t b;
    int nb;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nb = p.size() / 64;
    for (int bi = 0; bi < nb; bi++) begin
      b.data = '0;
      for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[bi*64+j];
      b.first = (bi == 0);
      b.last  = (bi == nb - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic send_bytes(input bq_t m, input bit do_last);
    int t;
    for (int i = 0; i < m.size(); i++) begin
      if (rand_idle && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = do_last && (i == m.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        t++;
        if (t > 3000) break;
      end
      if (t > 3000) begin
        n_vec++; n_bad++;
        $display("FAIL in_ready_timeout: byte %0d never accepted", i);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input bq_t m);
    model(m);
    send_bytes(m, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d blocks outstanding, want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.blk_valid && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("blk_valid_rises", 520'(bus.blk_valid), 520'd1);
  endtask

  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.blk_ready = ($urandom_range(0, 3) != 0);
        1:       bus.blk_ready = 1'b1;
        default: bus.blk_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every block handshake, and checks hold-stability while stalled
  initial begin
    logic stall;
    logic [513:0] held;
    blk_t e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else if (bus.blk_valid) begin
        check("in_ready_in_emit", 520'(bus.in_ready), 520'd0);
        if (stall) check("held_block", 520'({bus.blk_data, bus.blk_first, bus.blk_last}), 520'(held));
        if (bus.blk_ready) begin
          stall = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_block: got %0h want none", bus.blk_data);
          end else begin
            e = exp_q.pop_front();
            check("blk_data", 520'(bus.blk_data), 520'(e.data));
            check("blk_first", 520'(bus.blk_first), 520'(e.first));
            check("blk_last", 520'(bus.blk_last), 520'(e.last));
          end
        end else begin
          stall = 1'b1;
          held  = {bus.blk_data, bus.blk_first, bus.blk_last};
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    bq_t m;
    bq_t abc;
    string s;
    int len;
    int edge_lens[8] = '{55, 56, 57, 63, 64, 65, 119, 128};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    abc = '{8'h61, 8'h62, 8'h63};

    #2;
    check("rst_outputs", 520'({bus.in_ready, bus.blk_valid, bus.blk_first, bus.blk_last, bus.blk_data}), 520'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("in_ready_before_edge", 520'(bus.in_ready), 520'd0);
    @(posedge clk); #1;
    check("in_ready_after_edge", 520'(bus.in_ready), 520'd1);

    send_msg(abc);
    drain();

    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m = {};
    for (int i = 0; i < s.len(); i++) m.push_back(8'(s[i]));
    send_msg(m);
    drain();

    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h00);
    send_msg(m);
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    send_msg(m);
    drain();

    send_msg(abc);
    send_msg(abc);
    drain();

    @(negedge clk) rdy_mode = 2;
    @(posedge clk); #1;
    send_msg(abc);
    wait_valid();
    repeat (10) @(posedge clk);
    @(negedge clk) rdy_mode = 1;
    drain();

    rdy_mode  = 0;
    rand_idle = 1'b1;
    for (int n = 0; n < 24; n++) begin
      len = (n % 3 == 0) ? edge_lens[(n / 3) % 8] : $urandom_range(1, 150);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_msg(m);
    end
    drain();

    rand_idle = 1'b0;
    @(negedge clk) rdy_mode = 2;
    @(posedge clk); #1;
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    send_bytes(m, 1'b0);
    wait_valid();
    #2 rst = 1'b0;
    #1;
    check("mid_emit_rst_outputs", 520'({bus.in_ready, bus.blk_valid, bus.blk_first, bus.blk_last, bus.blk_data}), 520'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    rdy_mode = 1;
    @(posedge clk); #1;
    send_msg(abc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
